// File: rtl/sized_ball.sv
// Square ball of half-width RADIUS that steps one pixel per move request and
// reverses an axis when the pixels bordering it in the direction of travel are occupied.
module sized_ball #(
    parameter int unsigned RADIUS     = 1,
    parameter int unsigned XLOC_START = 335,
    parameter int unsigned YLOC_START = 457,
    parameter bit          XDIR_START = 1'b0,
    parameter bit          YDIR_START = 1'b0,
    parameter int unsigned YLOST      = 478
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixpulse,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       empty,
    input  logic       move,
    input  logic       launch,
    output logic       draw_ball,
    output logic [9:0] xloc,
    output logic [9:0] yloc,
    output logic       bounce,
    output logic [7:0] hits,
    output logic       lost,
    output logic [1:0] state
);

    localparam int unsigned CW = 10;
    localparam int unsigned AW = 11;
    localparam int unsigned C  = RADIUS + 1;
    localparam int unsigned VW = 2 * RADIUS + 3;

    localparam logic [AW-1:0] RAD_A   = AW'(RADIUS);
    localparam logic [AW-1:0] C_A     = AW'(C);
    localparam logic [AW-1:0] YLOST_A = AW'(YLOST);
    localparam logic [CW-1:0] XLOC_S  = CW'(XLOC_START);
    localparam logic [CW-1:0] YLOC_S  = CW'(YLOC_START);

    function automatic logic [VW-1:0] range_mask(input int unsigned lo, input int unsigned hi);
        logic [VW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < VW; i++) begin
            m[i] = (i >= lo) && (i <= hi);
        end
        return m;
    endfunction

    // Upper/left half of a side (centre included) and lower/right half.
    localparam logic [VW-1:0] HI_MASK = range_mask(C, 2 * RADIUS + 1);
    localparam logic [VW-1:0] LO_MASK = range_mask(1, C);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOST = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] xloc_q, xloc_d, yloc_q, yloc_d;
    logic          xdir_q, xdir_d, ydir_q, ydir_d;
    logic          upd_q, upd_d;
    logic          bounce_q, bounce_d;
    logic [7:0]    hits_q, hits_d;
    logic          lost_q, lost_d;
    logic [VW-1:0] lft_q, lft_d, rgt_q, rgt_d, top_q, top_d, bot_q, bot_d;

    logic [AW-1:0] hc_a, vc_a, xl_a, yl_a, col_idx, row_idx;
    logic [VW-1:0] col_hot, row_hot;
    logic          at_lft, at_rgt, at_top, at_bot, in_col, in_row;
    logic          blk_lft_up, blk_lft_dn, blk_rgt_up, blk_rgt_dn;
    logic          blk_top_lft, blk_top_rgt, blk_bot_lft, blk_bot_rgt;
    logic          crn_ul, crn_ur, crn_dl, crn_dr, xblk, yblk;

    // Widened coordinates: all comparisons are done with additions so nothing wraps near 0.
    assign hc_a = {1'b0, hcount};
    assign vc_a = {1'b0, vcount};
    assign xl_a = {1'b0, xloc_q};
    assign yl_a = {1'b0, yloc_q};

    assign draw_ball = (hc_a + RAD_A >= xl_a) && (hc_a <= xl_a + RAD_A) &&
                       (vc_a + RAD_A >= yl_a) && (vc_a <= yl_a + RAD_A);

    assign at_lft  = (hc_a + C_A == xl_a);
    assign at_rgt  = (hc_a == xl_a + C_A);
    assign at_top  = (vc_a + C_A == yl_a);
    assign at_bot  = (vc_a == yl_a + C_A);
    assign in_col  = (vc_a + C_A >= yl_a) && (vc_a <= yl_a + C_A);
    assign in_row  = (hc_a + C_A >= xl_a) && (hc_a <= xl_a + C_A);
    assign col_idx = yl_a + C_A - vc_a;
    assign row_idx = xl_a + C_A - hc_a;

    always_comb begin
        col_hot = '0;
        row_hot = '0;
        for (int unsigned i = 0; i < VW; i++) begin
            col_hot[i] = (col_idx == AW'(i));
            row_hot[i] = (row_idx == AW'(i));
        end
    end

    assign blk_lft_up  = |(lft_q & HI_MASK);
    assign blk_lft_dn  = |(lft_q & LO_MASK);
    assign blk_rgt_up  = |(rgt_q & HI_MASK);
    assign blk_rgt_dn  = |(rgt_q & LO_MASK);
    assign blk_top_lft = |(top_q & HI_MASK);
    assign blk_top_rgt = |(top_q & LO_MASK);
    assign blk_bot_lft = |(bot_q & HI_MASK);
    assign blk_bot_rgt = |(bot_q & LO_MASK);

    // A corner pixel only matters when it is the sole obstruction on its two sides.
    assign crn_ul = (lft_q[VW-1] | top_q[VW-1]) & ~blk_lft_up & ~blk_top_lft;
    assign crn_ur = (rgt_q[VW-1] | top_q[0])    & ~blk_rgt_up & ~blk_top_rgt;
    assign crn_dl = (lft_q[0]    | bot_q[VW-1]) & ~blk_lft_dn & ~blk_bot_lft;
    assign crn_dr = (rgt_q[0]    | bot_q[0])    & ~blk_rgt_dn & ~blk_bot_rgt;

    assign xblk = xdir_q ? (ydir_q ? (blk_rgt_dn | crn_dr) : (blk_rgt_up | crn_ur))
                         : (ydir_q ? (blk_lft_dn | crn_dl) : (blk_lft_up | crn_ul));
    assign yblk = ydir_q ? (xdir_q ? (blk_bot_rgt | crn_dr) : (blk_bot_lft | crn_dl))
                         : (xdir_q ? (blk_top_rgt | crn_ur) : (blk_top_lft | crn_ul));

    always_comb begin
        state_d  = state_q;
        xloc_d   = xloc_q;
        yloc_d   = yloc_q;
        xdir_d   = xdir_q;
        ydir_d   = ydir_q;
        upd_d    = upd_q;
        bounce_d = bounce_q;
        hits_d   = hits_q;
        lost_d   = lost_q;
        lft_d    = lft_q;
        rgt_d    = rgt_q;
        top_d    = top_q;
        bot_d    = bot_q;
        if (pixpulse) begin
            upd_d    = 1'b0;
            bounce_d = 1'b0;
            if (upd_q) begin
                lft_d = '0;
                rgt_d = '0;
                top_d = '0;
                bot_d = '0;
            end else if (!empty) begin
                if (at_lft && in_col) lft_d = lft_q | col_hot;
                if (at_rgt && in_col) rgt_d = rgt_q | col_hot;
                if (at_top && in_row) top_d = top_q | row_hot;
                if (at_bot && in_row) bot_d = bot_q | row_hot;
            end
            case (state_q)
                IDLE: if (launch) state_d = RUN;
                RUN: begin
                    if (move) begin
                        xdir_d = xdir_q ^ xblk;
                        ydir_d = ydir_q ^ yblk;
                        xloc_d = xdir_d ? xloc_q + 10'd1 : xloc_q - 10'd1;
                        yloc_d = ydir_d ? yloc_q + 10'd1 : yloc_q - 10'd1;
                        upd_d  = 1'b1;
                        if (xblk || yblk) begin
                            bounce_d = 1'b1;
                            if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
                        end
                        if (ydir_d && ({1'b0, yloc_d} >= YLOST_A)) begin
                            state_d = LOST;
                            lost_d  = 1'b1;
                        end
                    end
                end
                LOST: begin
                    if (launch) begin
                        state_d = IDLE;
                        xloc_d  = XLOC_S;
                        yloc_d  = YLOC_S;
                        xdir_d  = XDIR_START;
                        ydir_d  = YDIR_START;
                        lost_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            xloc_q   <= XLOC_S;
            yloc_q   <= YLOC_S;
            xdir_q   <= XDIR_START;
            ydir_q   <= YDIR_START;
            upd_q    <= 1'b0;
            bounce_q <= 1'b0;
            hits_q   <= 8'd0;
            lost_q   <= 1'b0;
            lft_q    <= '0;
            rgt_q    <= '0;
            top_q    <= '0;
            bot_q    <= '0;
        end else begin
            state_q  <= state_d;
            xloc_q   <= xloc_d;
            yloc_q   <= yloc_d;
            xdir_q   <= xdir_d;
            ydir_q   <= ydir_d;
            upd_q    <= upd_d;
            bounce_q <= bounce_d;
            hits_q   <= hits_d;
            lost_q   <= lost_d;
            lft_q    <= lft_d;
            rgt_q    <= rgt_d;
            top_q    <= top_d;
            bot_q    <= bot_d;
        end
    end

    assign xloc   = xloc_q;
    assign yloc   = yloc_q;
    assign bounce = bounce_q;
    assign hits   = hits_q;
    assign lost   = lost_q;
    assign state  = state_q;

endmodule

// File: tb/tb_sized_ball.sv
// Randomized scoreboard bench for sized_ball against a geometric model of
// neighbour occupancy, bounces, loss and relaunch.
module tb_sized_ball;

    localparam int R  = 2;
    localparam int C  = R + 1;
    localparam int XS = 335;
    localparam int YS = 457;
    localparam int YL = 478;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pixpulse = 1'b0;
    logic [9:0] hcount = 10'd1023;
    logic [9:0] vcount = 10'd1023;
    logic       empty = 1'b1;
    logic       move = 1'b0;
    logic       launch = 1'b0;
    logic       draw_ball;
    logic [9:0] xloc, yloc;
    logic       bounce;
    logic [7:0] hits;
    logic       lost;
    logic [1:0] state;

    sized_ball #(
        .RADIUS(R), .XLOC_START(XS), .YLOC_START(YS),
        .XDIR_START(1'b0), .YDIR_START(1'b0), .YLOST(YL)
    ) dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .empty(empty), .move(move), .launch(launch), .draw_ball(draw_ball),
        .xloc(xloc), .yloc(yloc), .bounce(bounce), .hits(hits), .lost(lost), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int b;
        int h;
        int l;
        int s;
    } exp_t;

    exp_t exp_q[$];
    int   draw_q[$];
    event draw_ev;
    bit   obs = 1'b0;
    bit   obs_q = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: ball position/direction, hit count, state code, lost flag.
    int mx, my, mh, mst;
    bit mdx, mdy, mlost;
    bit occ[int];

    task automatic chk(input string nm, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic int key(input int x, input int y);
        return y * 2048 + x;
    endfunction

    function automatic bit occ_at(input int x, input int y);
        return occ.exists(key(x, y)) ? occ[key(x, y)] : 1'b0;
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic model_reset();
        mx = XS; my = YS; mdx = 1'b0; mdy = 1'b0;
        mh = 0; mst = 0; mlost = 1'b0;
    endtask

    task automatic push_exp(input int b);
        exp_t e;
        e.x = mx; e.y = my; e.b = b; e.h = mh; e.l = int'(mlost); e.s = mst;
        exp_q.push_back(e);
    endtask

    // Obstruction: the side strip from the centre line to the far edge in the
    // direction of travel, or the leading corner when both strips are clear.
    task automatic model_step(output int bnc);
        int sx, sy;
        bit xs, ys, cr, xb, yb;
        sx = mdx ? 1 : -1;
        sy = mdy ? 1 : -1;
        xs = 1'b0;
        ys = 1'b0;
        for (int k = 0; k <= R; k++) begin
            xs |= occ_at(mx + sx * C, my + sy * k);
            ys |= occ_at(mx + sx * k, my + sy * C);
        end
        cr = occ_at(mx + sx * C, my + sy * C) && !xs && !ys;
        xb = xs || cr;
        yb = ys || cr;
        mx  = xb ? mx - sx : mx + sx;
        my  = yb ? my - sy : my + sy;
        mdx = mdx ^ xb;
        mdy = mdy ^ yb;
        bnc = (xb || yb) ? 1 : 0;
        if (xb || yb) mh = (mh < 255) ? mh + 1 : 255;
        if (mdy && my >= YL) begin
            mst = 2;
            mlost = 1'b1;
        end
    endtask

    task automatic drive(input bit pp, input bit mv, input bit ln, input int h, input int v,
                         input bit emp, input bit ob);
        @(negedge clk);
        pixpulse = pp; move = mv; launch = ln;
        hcount = 10'(h); vcount = 10'(v); empty = emp; obs = ob;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pixpulse = 1'b0; move = 1'b0; launch = 1'b0; obs = 1'b1;
        model_reset();
        push_exp(0);
        @(negedge clk);
        rst = 1'b0; obs = 1'b0;
    endtask

    // One pixpulse outside RUN (or a RUN pulse with move low).
    task automatic pulse_cycle(input bit mv, input bit ln);
        drive(1'b1, mv, ln, 1023, 1023, 1'b1, 1'b1);
        if (mst == 0 && ln) mst = 1;
        else if (mst == 2 && ln) begin
            mx = XS; my = YS; mdx = 1'b0; mdy = 1'b0; mlost = 1'b0; mst = 0;
        end
        push_exp(0);
    endtask

    task automatic run_step(input bit ln);
        int bnc;
        drive(1'b1, 1'b1, ln, 1023, 1023, 1'b1, 1'b1);
        model_step(bnc);
        push_exp(bnc);
        drive(1'b1, 1'b0, 1'b0, 1023, 1023, 1'b1, 1'b1);
        push_exp(0);
    endtask

    // Present every pixel of a window around the ball; ring pixels at distance C
    // use p_ring percent occupancy, all others p_other percent (they must be ignored).
    task automatic scan(input int half, input int p_ring, input int p_other);
        occ.delete();
        for (int dy = -half; dy <= half; dy++) begin
            for (int dx = -half; dx <= half; dx++) begin
                int h, v, cheb, p;
                bit o;
                h = mx + dx;
                v = my + dy;
                if (h >= 0 && h < 1024 && v >= 0 && v < 1024) begin
                    cheb = (iabs(dx) > iabs(dy)) ? iabs(dx) : iabs(dy);
                    p = (cheb == C) ? p_ring : p_other;
                    o = (int'($urandom_range(99)) < p);
                    occ[key(h, v)] = o;
                    drive(1'b1, 1'b0, 1'b0, h, v, !o, 1'b0);
                    #2;
                    draw_q.push_back((iabs(dx) <= R && iabs(dy) <= R) ? 1 : 0);
                    ->draw_ev;
                end
            end
        end
    endtask

    always @(posedge clk) obs_q <= obs;

    always @(negedge clk) begin
        exp_t e;
        if (obs_q) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: got no expectation, required one");
            end else begin
                e = exp_q.pop_front();
                chk("xloc",   int'(xloc),   e.x);
                chk("yloc",   int'(yloc),   e.y);
                chk("bounce", int'(bounce), e.b);
                chk("hits",   int'(hits),   e.h);
                chk("lost",   int'(lost),   e.l);
                chk("state",  int'(state),  e.s);
            end
        end
    end

    always begin
        int want;
        @(draw_ev);
        if (draw_q.size() != 0) begin
            want = draw_q.pop_front();
            chk("draw_ball", int'(draw_ball), want);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();
        repeat (4) pulse_cycle(1'b1, 1'b0);
        pulse_cycle(1'b0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            if (mst == 1) begin
                scan(C + 1, int'($urandom_range(15)), 30);
                run_step(1'($urandom_range(1)));
            end else begin
                pulse_cycle(1'($urandom_range(1)), 1'($urandom_range(1)));
            end
        end

        // Bounce off a full enclosure, then run down into the lost row.
        do_reset();
        pulse_cycle(1'b0, 1'b1);
        scan(C, 100, 0);
        run_step(1'b0);
        for (int i = 0; i < 40 && mst == 1; i++) begin
            scan(C + 1, 0, 30);
            run_step(1'b0);
        end
        repeat (3) pulse_cycle(1'b1, 1'b0);
        pulse_cycle(1'b0, 1'b1);
        pulse_cycle(1'b0, 1'b1);

        // Enclosed ball bounces on every step until hits saturates.
        repeat (300) begin
            scan(C, 100, 0);
            run_step(1'b0);
        end

        // Reset arriving during a blocked step must drop that step.
        scan(C, 100, 0);
        @(negedge clk);
        pixpulse = 1'b1; move = 1'b1; launch = 1'b0; obs = 1'b0;
        hcount = 10'd1023; vcount = 10'd1023; empty = 1'b1;
        #2 rst = 1'b1;
        do_reset();

        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        chk("draw_drained", draw_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
